mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of cycles each memory access holds the bus; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request; requester 0 is the CPU core, requester 1 is the program loader.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-006 addr0, addr1  input  8 each  target memory address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 gnt0, gnt1  output  1 each  high for every cycle the requester owns the memory bus.
REQ-009 done0, done1  output  1 each  single-cycle completion pulse.
REQ-010 rdata0, rdata1  output  8 each  read result, registered per requester.
REQ-011 mem_addr  output  8  address to memory.
REQ-012 mem_wdata  output  8  data driven onto the bidirectional memory data bus.
REQ-013 mem_write_en  output  1  memory write strobe.
REQ-014 mem_drive  output  1  tristate enable for mem_data at the top level; 1 = arbiter drives.
REQ-015 mem_rdata  input  8  data read back from the memory data bus.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-018 IDLE: when any req is high, select the winner, latch its we/addr/wdata and go to ACCESS next cycle; otherwise stay.
REQ-019 Arbitration SHALL be round-robin with a 1-bit priority pointer: the favoured requester wins a tie, and the pointer then moves to the other requester; a lone requester always wins.
REQ-020 After reset the pointer SHALL favour requester 0.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-022 During ACCESS: gnt of the winner = 1; mem_addr = latched addr; writes assert mem_write_en = mem_drive = 1 and mem_wdata = latched wdata; reads hold both strobes at 0.
REQ-023 For a read, mem_rdata SHALL be captured into the winner's rdata on the last ACCESS cycle.
REQ-024 DONE SHALL last one cycle: pulse the winner's done, deassert gnt and all mem strobes, then go to IDLE.
REQ-025 The req-to-done latency SHALL be exactly WAIT_CYCLES+2 cycles (req sampled in cycle N, done in cycle N+WAIT_CYCLES+1).
REQ-026 Outside ACCESS: mem_addr = 0, mem_wdata = 0, mem_write_en = 0, mem_drive = 0.
REQ-027 A requester SHALL hold req/we/addr/wdata stable until its done; the arbiter ignores input changes after latching.
REQ-028 If req drops mid-ACCESS, the access SHALL still complete and done still pulse.
REQ-029 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-030 rdata SHALL hold its value until that requester's next read completes; writes leave rdata unchanged.
REQ-031 At most one gnt and one done SHALL be high in any cycle; mem_write_en implies mem_drive.

Reset
REQ-032 On rst = 1 at a clock edge, in any state including mid-ACCESS: state = IDLE, counter = 0, pointer favours requester 0, and all outputs = 0 (gnt, done, rdata, mem_*, busy).
REQ-033 An access interrupted by reset SHALL NOT produce a done pulse.

Verification
REQ-034 WAIT_CYCLES=2: req0 read addr 0x10 with mem_rdata=0xA5 -> gnt0 high 2 cycles, done0 at cycle N+3, rdata0=0xA5.
REQ-035 req1 write addr 0x20 data 0x3C -> mem_write_en=mem_drive=1 and mem_addr=0x20, mem_wdata=0x3C for 2 cycles; done1 pulses; rdata1 unchanged.
REQ-036 req0 and req1 both held high from reset -> grants alternate 0,1,0,1; each done is followed by one IDLE cycle.
REQ-037 rst asserted in the 2nd ACCESS cycle of a write -> next cycle all outputs 0, no done; a subsequent tie grants requester 0.
REQ-038 req0 dropped during ACCESS -> done0 still pulses; with no further requests the block returns to IDLE with busy=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter. Requester 0 is the CPU core,
// requester 1 the program loader. A three-state FSM (IDLE -> ACCESS -> DONE)
// owns the bus for WAIT_CYCLES cycles per access. Ties are broken by a
// round-robin pointer. Read data is captured into a per-requester register.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write_en,
  output logic       mem_drive,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;      // favoured requester on a tie
  logic        owner_q, owner_d;  // requester currently owning the bus
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        win;

  // State register; synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      rdata0_q <= 8'd0;
      rdata1_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic: arbitration, request latching, wait counting, read capture.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = ptr_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Lone requester wins outright; a tie goes to the pointer.
          win     = (req0 && req1) ? ptr_q : req1;
          owner_d = win;
          ptr_d   = ~win;
          we_d    = win ? we1    : we0;
          addr_d  = win ? addr1  : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = WAIT_LD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from the registered state.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    mem_addr     = 8'd0;
    mem_wdata    = 8'd0;
    mem_write_en = 1'b0;
    mem_drive    = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      ACCESS: begin
        gnt0     = ~owner_q;
        gnt1     = owner_q;
        mem_addr = addr_q;
        if (we_q) begin
          mem_write_en = 1'b1;
          mem_drive    = 1'b1;
          mem_wdata    = wdata_q;
        end
      end
      DONE: begin
        done0 = ~owner_q;
        done1 = owner_q;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with WAIT_CYCLES = 2. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write_en, mem_drive, busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write_en (mem_write_en),
    .mem_drive    (mem_drive),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus strobes all idle and nobody granted or completing.
  task automatic check_quiet(input string tag);
    check({tag, " gnt"},  {6'd0, gnt1, gnt0}, 8'h00);
    check({tag, " done"}, {6'd0, done1, done0}, 8'h00);
    check({tag, " mem_addr"}, mem_addr, 8'h00);
    check({tag, " mem_wdata"}, mem_wdata, 8'h00);
    check({tag, " strobes"}, {6'd0, mem_write_en, mem_drive}, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    mem_rdata = 8'h00;
    tick();
    tick();
    check_quiet("reset");
    check("reset busy", {7'd0, busy}, 8'h00);
    check("reset rdata0", rdata0, 8'h00);
    check("reset rdata1", rdata1, 8'h00);
    rst = 1'b0;

    // ---- Read by requester 0: addr 0x10, memory returns 0xA5 ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; mem_rdata = 8'hA5;
    tick();  // ACCESS 1
    check("rd acc1 gnt", {6'd0, gnt1, gnt0}, 8'h01);
    check("rd acc1 addr", mem_addr, 8'h10);
    check("rd acc1 strobes", {6'd0, mem_write_en, mem_drive}, 8'h00);
    check("rd acc1 busy", {7'd0, busy}, 8'h01);
    tick();  // ACCESS 2
    check("rd acc2 gnt", {6'd0, gnt1, gnt0}, 8'h01);
    check("rd acc2 done", {6'd0, done1, done0}, 8'h00);
    tick();  // DONE, req sampled two edges earlier -> N+3
    check("rd done", {6'd0, done1, done0}, 8'h01);
    check("rd done gnt", {6'd0, gnt1, gnt0}, 8'h00);
    check("rd rdata0", rdata0, 8'hA5);
    check("rd done busy", {7'd0, busy}, 8'h01);
    req0 = 1'b0;
    mem_rdata = 8'h77;
    tick();  // IDLE
    check("rd idle busy", {7'd0, busy}, 8'h00);
    check_quiet("rd idle");
    check("rd rdata0 hold", rdata0, 8'hA5);

    // ---- Write by requester 1: addr 0x20, data 0x3C ----
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("wr gnt", {6'd0, gnt1, gnt0}, 8'h02);
      check("wr addr", mem_addr, 8'h20);
      check("wr wdata", mem_wdata, 8'h3C);
      check("wr strobes", {6'd0, mem_write_en, mem_drive}, 8'h03);
    end
    tick();  // DONE
    check("wr done", {6'd0, done1, done0}, 8'h02);
    check("wr done strobes", {6'd0, mem_write_en, mem_drive}, 8'h00);
    check("wr rdata1 unchanged", rdata1, 8'h00);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check("wr idle busy", {7'd0, busy}, 8'h00);

    // ---- Both held high from reset: grants alternate 0,1,0,1 ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h01; addr1 = 8'h02; mem_rdata = 8'h5A;
    for (int g = 0; g < 4; g++) begin
      tick();  // ACCESS 1
      check("rr gnt", {6'd0, gnt1, gnt0}, (g % 2 == 0) ? 8'h01 : 8'h02);
      check("rr addr", mem_addr, (g % 2 == 0) ? 8'h01 : 8'h02);
      tick();  // ACCESS 2
      tick();  // DONE
      check("rr done", {6'd0, done1, done0}, (g % 2 == 0) ? 8'h01 : 8'h02);
      tick();  // IDLE between accesses
      check("rr idle busy", {7'd0, busy}, 8'h00);
      check("rr idle gnt", {6'd0, gnt1, gnt0}, 8'h00);
    end
    check("rr rdata0", rdata0, 8'h5A);
    req0 = 1'b0; req1 = 1'b0;

    // ---- Reset in the 2nd ACCESS cycle of a write; pointer left at 1 ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h99;
    tick();  // ACCESS 1 (sampled in the IDLE cycle above)
    tick();  // ACCESS 2
    check("rst-wr acc2 strobes", {6'd0, mem_write_en, mem_drive}, 8'h03);
    check("rst-wr acc2 wdata", mem_wdata, 8'h99);
    rst = 1'b1;
    tick();
    check_quiet("rst-wr after");
    check("rst-wr busy", {7'd0, busy}, 8'h00);
    check("rst-wr rdata0", rdata0, 8'h00);
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h44;
    mem_rdata = 8'hC3;
    tick();  // ACCESS 1 of the tie
    check("rst tie gnt", {6'd0, gnt1, gnt0}, 8'h01);
    check("rst no done", {6'd0, done1, done0}, 8'h00);

    // ---- req0 dropped mid-ACCESS: access still completes ----
    req0 = 1'b0; req1 = 1'b0;
    tick();  // ACCESS 2
    check("drop acc2 gnt", {6'd0, gnt1, gnt0}, 8'h01);
    tick();  // DONE
    check("drop done", {6'd0, done1, done0}, 8'h01);
    check("drop rdata0", rdata0, 8'hC3);
    tick();
    check("drop idle busy", {7'd0, busy}, 8'h00);
    tick();
    check("drop stay idle busy", {7'd0, busy}, 8'h00);
    check_quiet("drop stay idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
